rs_systematic_encoder: RTL
==========================

Name: rs_systematic_encoder

Overview:
Streaming systematic Reed-Solomon encoder over GF(2^8). It is the upstream companion of the decoder peripheral and produces the codewords that the decoder consumes, for loopback and self-test.
- Message symbols pass through unchanged.
- An LFSR divides the message by a software-loaded monic generator polynomial.
- The remainder (parity) is appended, highest-order symbol first.
- Field polynomial and lengths are runtime configuration, matching the decoder's register set.

Parameters:
MAX_PARITY, 32, maximum parity symbols (2 x MAX_ERRORS of the decoder)
SYM_W, 8, symbol width in bits; fixed at 8, GF(2^8) only

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
cfg_irr_poly  in  9  field polynomial, bit8 must be 1 (e.g. 0x11D)
cfg_msg_len  in  8  message symbols per block (k)
cfg_par_len  in  6  parity symbols per block (n-k)
gen_we  in  1  write strobe for one generator coefficient
gen_addr  in  5  coefficient index i (g_i, i < MAX_PARITY)
gen_data  in  8  coefficient value
start  in  1  single-cycle request to begin one block
in_valid  in  1  message symbol valid
in_data  in  8  message symbol, highest degree first
in_ready  out  1  encoder accepts in_data this cycle
out_valid  out  1  codeword symbol valid
out_data  out  8  codeword symbol
out_last  out  1  marks the final parity symbol
out_ready  in  1  sink accepts out_data
busy  out  1  block in progress
done  out  1  one-cycle pulse after out_last is accepted
cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset is asynchronous, active-low. It clears state to IDLE, r[0..MAX_PARITY-1]=0, g[*]=0, all counters=0, and deasserts out_valid, out_last, in_ready, busy, done and cfg_err.
- Generator storage: g_0..g_{p-1}; g_p=1 is implicit. gen_we writes g[gen_addr] when state is IDLE and is ignored otherwise.
- Start sequence:
  - start in IDLE checks: 1<=par_len<=MAX_PARITY, msg_len>=1, msg_len+par_len<=255.
  - If the check fails, cfg_err pulses on the next cycle and state stays IDLE.
  - If it passes, the configuration is latched, r[*]=0, the symbol counter is cleared and state goes to MSG.
  - start outside IDLE is ignored.
- FSM states and transitions:
  - IDLE: waits for start.
  - MSG: on the msg_len-th accepted input, go to PAR.
  - PAR: on the last parity load, go to DRAIN.
  - DRAIN: when the output register is empty or being consumed with out_last=1, go to IDLE and pulse done.
- Output stage is a single register. "Slot free" means !out_valid || out_ready.
- MSG:
  - in_ready = slot free.
  - On an in_valid && in_ready transfer: out_data <= in_data and out_valid <= 1 (latency 1 cycle).
  - LFSR update with fb = in_data ^ r[p-1]: r[i] <= r[i-1] ^ gfmul(fb,g_i) for 1<=i<p, and r[0] <= gfmul(fb,g_0).
  - Registers at index >= p stay 0.
- PAR:
  - in_ready=0.
  - Each cycle the slot is free: out_data <= r[p-1], out_valid <= 1, r[i] <= r[i-1], r[0] <= 0, parity counter++.
  - out_last <= 1 with the p-th parity symbol.
- In all states, a free slot with nothing to load clears out_valid and out_last.
- Output handshake: out_data, out_valid and out_last are held stable while out_valid && !out_ready. There are no bubbles when out_ready stays high.
- The total codeword is msg_len+par_len symbols.
- busy = (state != IDLE).
- Configuration inputs changing mid-block have no effect.
- Reset asserted mid-block aborts it immediately. No done pulse is produced, and g[*] is lost and must be reloaded.
- GF multiply: carry-less product, reduced modulo cfg_irr_poly (latched copy), fully combinational.

Decomposition:
- Shared include (rs_defs.vh): SYM_W, MAX_PARITY, MAX_BLOCK=255, state encodings, and the shared 0x11D default used in benches.
- Sub-module gf_mul_var: combinational multiply with inputs a, b, poly and output p. It is instantiated once per generator tap (MAX_PARITY copies) and is reusable by the decoder stages.

Test Plan:
- Poly 0x11D, p=2, g0=2, g1=3, k=1, in 01, out_ready=1 -> out 01,03,02; out_last on 02; done next cycle.
- Same config, k=2, in 01,00 -> out 01,00,07,06. The codeword evaluates to 0 at alpha^0 and alpha^1.
- Same as the k=2 case with out_ready toggled 1010... and in_valid gaps -> identical stream. Data is held while stalled and in_ready=0 whenever the slot is not free.
- Configuration rejection:
  - start with p=0 -> cfg_err pulse, busy=0.
  - start with k=224, p=32 -> cfg_err pulse.
  - start with k=223, p=32 -> accepted; 255 symbols out; the bench checks all 32 syndromes are 0 against the golden model.
- Guarded writes and restart: gen_we and start while busy are ignored (output unchanged vs. golden). A back-to-back start the cycle after done is accepted.
- Abort and recovery: rst_n pulsed low mid-PAR -> out_valid, busy and done drop asynchronously. After reloading g, the next block is correct.

Source files
------------

// File: rtl/rs_systematic_encoder_pkg.sv
// Shared constants, state encodings and config payload for the RS encoder slice.
package rs_systematic_encoder_pkg;

    localparam int unsigned RS_SYM_W      = 8;
    localparam int unsigned RS_MAX_PARITY = 32;
    localparam int unsigned RS_MAX_BLOCK  = 255;
    localparam int unsigned RS_POLY_W     = RS_SYM_W + 1;
    localparam int unsigned RS_LEN_W      = 8;
    localparam int unsigned RS_PLEN_W     = 6;
    localparam int unsigned RS_ADDR_W     = 5;

    localparam logic [RS_POLY_W-1:0] RS_DEFAULT_POLY = 9'h11D;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MSG   = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef struct packed {
        logic [RS_POLY_W-1:0] irr_poly;
        logic [RS_LEN_W-1:0]  msg_len;
        logic [RS_PLEN_W-1:0] par_len;
    } enc_cfg_t;

    // Block geometry check applied when a start request arrives.
    function automatic logic cfg_lengths_ok(input logic [RS_LEN_W-1:0]  msg_len,
                                            input logic [RS_PLEN_W-1:0] par_len,
                                            input int unsigned          max_par);
        logic [RS_LEN_W:0] total;
        total = (RS_LEN_W+1)'(msg_len) + (RS_LEN_W+1)'(par_len);
        return (par_len != '0) &&
               ((RS_LEN_W+1)'(par_len) <= (RS_LEN_W+1)'(max_par)) &&
               (msg_len != '0) &&
               (total <= (RS_LEN_W+1)'(RS_MAX_BLOCK));
    endfunction

endpackage

// File: rtl/rs_systematic_encoder_gf_mul_var.sv
// Combinational GF(2^8) multiply with a runtime field polynomial.
module gf_mul_var
    import rs_systematic_encoder_pkg::*;
(
    input  logic [RS_SYM_W-1:0]  a,
    input  logic [RS_SYM_W-1:0]  b,
    input  logic [RS_POLY_W-1:0] poly,
    output logic [RS_SYM_W-1:0]  p
);

    logic [RS_SYM_W-1:0]  acc;
    logic [RS_SYM_W-1:0]  sh;
    logic [RS_POLY_W-1:0] ext;

    // Shift-and-add: accumulate a*x^i for each set bit of b, reducing a*x^i as it grows.
    always_comb begin
        acc = '0;
        sh  = a;
        ext = '0;
        for (int i = 0; i < int'(RS_SYM_W); i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            ext = {sh, 1'b0};
            if (ext[RS_SYM_W]) begin
                ext = ext ^ poly;
            end
            sh = ext[RS_SYM_W-1:0];
        end
        p = acc;
    end

endmodule

// File: rtl/rs_systematic_encoder.sv
// Streaming systematic RS encoder: message pass-through, LFSR division, parity append.
module rs_systematic_encoder
    import rs_systematic_encoder_pkg::*;
#(
    parameter int unsigned MAX_PARITY = RS_MAX_PARITY,
    parameter int unsigned SYM_W      = RS_SYM_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SYM_W:0]        cfg_irr_poly,
    input  logic [RS_LEN_W-1:0]   cfg_msg_len,
    input  logic [RS_PLEN_W-1:0]  cfg_par_len,
    input  logic                  gen_we,
    input  logic [RS_ADDR_W-1:0]  gen_addr,
    input  logic [SYM_W-1:0]      gen_data,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [SYM_W-1:0]      in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [SYM_W-1:0]      out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    localparam int unsigned IDX_W = $clog2(MAX_PARITY);

    logic [1:0]            state_q;
    logic [1:0]            state_nxt;
    enc_cfg_t              cfg_q;
    logic [RS_LEN_W-1:0]   sym_cnt_q;
    logic [RS_PLEN_W-1:0]  par_cnt_q;
    logic [SYM_W-1:0]      r_q   [MAX_PARITY];
    logic [SYM_W-1:0]      g_q   [MAX_PARITY];
    logic [SYM_W-1:0]      r_sh  [MAX_PARITY];
    logic [SYM_W-1:0]      prod  [MAX_PARITY];
    logic [MAX_PARITY-1:0] tap_en;
    logic [SYM_W-1:0]      r_top;
    logic [SYM_W-1:0]      fb;

    logic slot_free;
    logic start_ok;
    logic start_bad;
    logic msg_fire;
    logic msg_last;
    logic par_fire;
    logic par_last;
    logic drain_end;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state_q == ST_MSG) && slot_free;
    assign busy      = (state_q != ST_IDLE);
    assign r_top     = r_q[IDX_W'(cfg_q.par_len - RS_PLEN_W'(1))];
    assign fb        = in_data ^ r_top;

    // Per-tap enable, shifted register view and one multiplier per generator coefficient.
    assign r_sh[0] = '0;
    for (genvar i = 0; i < int'(MAX_PARITY); i++) begin : g_tap
        assign tap_en[i] = (RS_PLEN_W'(i) < cfg_q.par_len);
        if (i > 0) begin : g_sh
            assign r_sh[i] = r_q[i-1];
        end
        gf_mul_var u_mul (
            .a    (fb),
            .b    (g_q[i]),
            .poly (cfg_q.irr_poly),
            .p    (prod[i])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_nxt = state_q;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        msg_fire  = 1'b0;
        msg_last  = 1'b0;
        par_fire  = 1'b0;
        par_last  = 1'b0;
        drain_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_lengths_ok(cfg_msg_len, cfg_par_len, MAX_PARITY)) begin
                        start_ok  = 1'b1;
                        state_nxt = ST_MSG;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            ST_MSG: begin
                msg_fire = in_valid && slot_free;
                msg_last = msg_fire && (sym_cnt_q == (cfg_q.msg_len - RS_LEN_W'(1)));
                if (msg_last) begin
                    state_nxt = ST_PAR;
                end
            end
            ST_PAR: begin
                par_fire = slot_free;
                par_last = par_fire && (par_cnt_q == (cfg_q.par_len - RS_PLEN_W'(1)));
                if (par_last) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drain_end = !out_valid || (out_ready && out_last);
                if (drain_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Latched block configuration and symbol/parity counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q     <= '0;
            sym_cnt_q <= '0;
            par_cnt_q <= '0;
        end else if (start_ok) begin
            cfg_q     <= '{irr_poly: cfg_irr_poly, msg_len: cfg_msg_len, par_len: cfg_par_len};
            sym_cnt_q <= '0;
            par_cnt_q <= '0;
        end else begin
            if (msg_fire) begin
                sym_cnt_q <= sym_cnt_q + RS_LEN_W'(1);
            end
            if (par_fire) begin
                par_cnt_q <= par_cnt_q + RS_PLEN_W'(1);
            end
        end
    end

    // Generator coefficient store, writable only between blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MAX_PARITY); i++) begin
                g_q[i] <= '0;
            end
        end else if (gen_we && (state_q == ST_IDLE)) begin
            g_q[gen_addr] <= gen_data;
        end
    end

    // Remainder LFSR: divide during MSG, shift out during PAR; taps at or above p held at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MAX_PARITY); i++) begin
                r_q[i] <= '0;
            end
        end else if (start_ok) begin
            for (int i = 0; i < int'(MAX_PARITY); i++) begin
                r_q[i] <= '0;
            end
        end else if (msg_fire) begin
            for (int i = 0; i < int'(MAX_PARITY); i++) begin
                r_q[i] <= tap_en[i] ? (r_sh[i] ^ prod[i]) : '0;
            end
        end else if (par_fire) begin
            for (int i = 0; i < int'(MAX_PARITY); i++) begin
                r_q[i] <= tap_en[i] ? r_sh[i] : '0;
            end
        end
    end

    // Single-entry output register plus status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            done    <= drain_end;
            cfg_err <= start_bad;
            if (msg_fire) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
            end else if (par_fire) begin
                out_data  <= r_top;
                out_valid <= 1'b1;
                out_last  <= par_last;
            end else if (slot_free) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
